user_uart_tx: RTL and testbench

//   Byte-stream UART transmitter (8N1, LSB first) inside the user project. It drives the

---
 rtl/user_uart_tx_if.sv | 20 ++
 rtl/user_uart_tx.sv | 137 +++++++++++++
 tb/tb_user_uart_tx.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/user_uart_tx_if.sv
// Byte push port of the UART transmitter: valid/ready handshake carrying one byte.
interface user_uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // Producer side: offers bytes, watches ready
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    // Transmitter side: accepts bytes, drives ready
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/user_uart_tx.sv
// 8N1 UART transmitter, LSB first, fed by a small byte FIFO.
// Frames are sent back-to-back with no idle gap while bytes are queued and tx_en is high.
module user_uart_tx #(
    parameter int CLKS_PER_BIT = 4167,
    parameter int DEPTH        = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             tx_en,
    user_uart_tx_if.slave    tx_port,
    output logic [CNT_W-1:0] fifo_count,
    output logic             tx_busy,
    output logic             uart_tx
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_nxt;
    logic [2:0]        bit_idx, bit_nxt;
    logic [7:0]        shift, shift_nxt;
    logic [7:0]        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              ready, push, pop, can_start, baud_last;
    logic              line_nxt, busy_nxt;

    assign ready            = (fifo_count != FULL);
    assign tx_port.tx_ready = ready;
    assign push             = tx_port.tx_valid && ready;
    assign can_start        = tx_en && (fifo_count != '0);
    assign baud_last        = (baud_cnt == BAUD_LAST);

    // FIFO storage: data captured only on an accepted push
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= tx_port.tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of 2)
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State register; line and busy are registered from the next-state view so a
    // start bit appears on the same edge that leaves IDLE
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_tx  <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            uart_tx  <= line_nxt;
            tx_busy  <= busy_nxt;
        end
    end

    // Shift register holds the byte in flight; no reset needed for payload
    always_ff @(posedge clock) begin
        shift <= shift_nxt;
    end

    // Next-state logic: baud counter restarts on every state entry
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + 1'b1;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (can_start) begin
                    state_nxt = START;
                    shift_nxt = mem[rd_ptr];
                end
            end
            START: begin
                if (baud_last) begin
                    state_nxt = DATA;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    bit_nxt   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_nxt = '0;
                    if (can_start) begin
                        state_nxt = START;
                        shift_nxt = mem[rd_ptr];
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: FIFO pop on frame launch, next line level and busy flag
    always_comb begin
        pop      = can_start && ((state == IDLE) || ((state == STOP) && baud_last));
        busy_nxt = (state_nxt != IDLE);
        case (state_nxt)
            START:   line_nxt = 1'b0;
            DATA:    line_nxt = shift_nxt[0];
            default: line_nxt = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_user_uart_tx.sv
// Self-checking bench for user_uart_tx: a line monitor decodes every frame and
// compares it against a queue of bytes the bench expects to see transmitted.
module tb_user_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int FRAME = 10 * CPB;

    logic             clock  = 1'b0;
    logic             resetb = 1'b1;
    logic             tx_en  = 1'b0;
    logic [CNT_W-1:0] fifo_count;
    logic             tx_busy;
    logic             uart_tx;

    user_uart_tx_if tx_if();

    user_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clock     (clock),
        .resetb    (resetb),
        .tx_en     (tx_en),
        .tx_port   (tx_if),
        .fifo_count(fifo_count),
        .tx_busy   (tx_busy),
        .uart_tx   (uart_tx)
    );

    always #5 clock = ~clock;

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;
    int frames = 0;
    int push_cyc = 0;
    logic [7:0] exp_q[$];
    int         starts[$];

    int               mon_k     = -1;
    logic             prev_line = 1'b1;
    logic [FRAME-1:0] cap;
    logic             busy_ok;
    int               start_cyc;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Ideal 8N1 waveform, one entry per clock: start low, data LSB first, stop high
    function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] b);
        logic [FRAME-1:0] f;
        for (int k = 0; k < FRAME; k++) begin
            if (k < CPB)          f[k] = 1'b0;
            else if (k < 9 * CPB) f[k] = b[(k - CPB) / CPB];
            else                  f[k] = 1'b1;
        end
        return f;
    endfunction

    // Line monitor: capture FRAME samples after each falling edge and score them
    always @(negedge clock) begin
        if (!resetb) begin
            mon_k     = -1;
            prev_line = 1'b1;
        end else if (mon_k < 0) begin
            if (prev_line && !uart_tx) begin
                cap       = '0;
                cap[0]    = uart_tx;
                busy_ok   = tx_busy;
                start_cyc = cyc;
                mon_k     = 1;
            end
            prev_line = uart_tx;
        end else begin
            cap[mon_k] = uart_tx;
            busy_ok    = busy_ok & tx_busy;
            mon_k++;
            if (mon_k == FRAME) begin
                logic [7:0] b;
                starts.push_back(start_cyc);
                frames++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got %0h, required no frame", cap);
                end else begin
                    b = exp_q.pop_front();
                    check("frame_bits", 64'(cap), 64'(frame_bits(b)));
                    check("frame_busy", busy_ok, 1'b1);
                end
                mon_k     = -1;
                prev_line = uart_tx;
            end
        end
    end

    // Offer one byte for one clock edge; valid stays high for the caller to drop
    task automatic push(input logic [7:0] b, output bit acc);
        tx_if.tx_data  = b;
        tx_if.tx_valid = 1'b1;
        #1;
        acc = tx_if.tx_ready;
        @(posedge clock);
        #1;
        push_cyc = cyc;
        if (acc) exp_q.push_back(b);
    endtask

    task automatic idle(input int n);
        tx_if.tx_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int i = 0;
        while (frames < n && i < budget) begin
            @(negedge clock);
            #1;
            i++;
        end
        check(name, frames >= n, 1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   acc;
        logic line_ok;
        int   f0, s0, en_cyc, i;
        logic [7:0] b;

        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b0;

        // Reset values
        #2 resetb = 1'b0;
        #10;
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_ready", tx_if.tx_ready, 1'b1);
        check("rst_count", fifo_count, 0);
        @(negedge clock);
        resetb  = 1'b1;
        line_ok = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (uart_tx !== 1'b1) line_ok = 1'b0;
        end
        check("idle_line", line_ok, 1'b1);

        // Single byte latency and shape
        tx_en = 1'b1;
        @(negedge clock);
        f0 = frames;
        push(8'hA5, acc);
        tx_if.tx_valid = 1'b0;
        check("t2_accept", acc, 1'b1);
        check("t2_pre_line", uart_tx, 1'b1);
        check("t2_pre_count", fifo_count, 1);
        wait_frames(f0 + 1, FRAME + 20, "t2_frame_timeout");
        check("t2_start_latency", starts[starts.size() - 1] - push_cyc, 1);
        @(negedge clock);
        check("t2_busy_after", tx_busy, 1'b0);
        check("t2_line_after", uart_tx, 1'b1);

        // Back-to-back pushes, full FIFO, no inter-frame gap
        idle(3);
        f0 = frames;
        s0 = starts.size();
        for (int k = 0; k < 5; k++) begin
            push(8'h40 + 8'(k), acc);
            check("t3_accept", acc, 1'b1);
        end
        check("t3_full_count", fifo_count, 4);
        check("t3_full_ready", tx_if.tx_ready, 1'b0);
        push(8'h45, acc);
        check("t3_sixth_rejected", acc, 1'b0);
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'hFF;
        wait_frames(f0 + 5, 5 * FRAME + 40, "t3_frames_timeout");
        for (int k = 1; k < 5; k++) begin
            if (starts.size() > s0 + k)
                check("t3_no_gap", starts[s0 + k] - starts[s0 + k - 1], FRAME);
        end
        check("t3_drained", fifo_count, 0);

        // tx_en gating
        idle(5);
        tx_en = 1'b0;
        f0 = frames;
        push(8'h51, acc);
        tx_if.tx_valid = 1'b0;
        repeat (100) @(negedge clock);
        check("t4_gated_no_frame", frames - f0, 0);
        check("t4_gated_line", uart_tx, 1'b1);
        check("t4_gated_count", fifo_count, 1);
        tx_en  = 1'b1;
        en_cyc = cyc;
        @(negedge clock);
        push(8'h52, acc);
        push(8'h53, acc);
        tx_if.tx_valid = 1'b0;
        repeat (15) @(negedge clock);
        tx_en = 1'b0;
        wait_frames(f0 + 1, FRAME + 20, "t4_frame_timeout");
        check("t4_start_after_en", starts[starts.size() - 1] - en_cyc, 1);
        repeat (60) @(negedge clock);
        check("t4_hold_frames", frames - f0, 1);
        check("t4_hold_count", fifo_count, 2);
        tx_en = 1'b1;
        wait_frames(f0 + 3, 2 * FRAME + 20, "t4_resume_timeout");

        // Reset during data bit 3 with two bytes queued
        idle(5);
        push(8'h61, acc);
        push(8'h62, acc);
        push(8'h63, acc);
        tx_if.tx_valid = 1'b0;
        repeat (17) @(negedge clock);
        check("t5_pre_count", fifo_count, 2);
        check("t5_pre_line", uart_tx, 1'b0);
        #1 resetb = 1'b0;
        #1;
        check("t5_async_line", uart_tx, 1'b1);
        check("t5_async_busy", tx_busy, 1'b0);
        check("t5_async_count", fifo_count, 0);
        exp_q.delete();
        repeat (3) @(negedge clock);
        resetb  = 1'b1;
        f0      = frames;
        line_ok = 1'b1;
        repeat (100) begin
            @(negedge clock);
            if (uart_tx !== 1'b1) line_ok = 1'b0;
        end
        check("t5_no_frame", frames - f0, 0);
        check("t5_line_idle", line_ok, 1'b1);
        check("t5_count", fifo_count, 0);

        // Randomised pushes with tx_en toggling and data changing after push
        for (int it = 0; it < 25; it++) begin
            tx_en = ($urandom_range(0, 3) != 0);
            idle($urandom_range(0, 50));
            b   = 8'($urandom);
            acc = 1'b0;
            i   = 0;
            while (!acc && i < 200) begin
                push(b, acc);
                if (!acc) tx_en = 1'b1;
                i++;
            end
            check("rand_accept", acc, 1'b1);
            tx_if.tx_valid = 1'b0;
            tx_if.tx_data  = 8'($urandom);
        end
        tx_en = 1'b1;
        i = 0;
        while (exp_q.size() != 0 && i < (DEPTH + 2) * FRAME + 50) begin
            @(negedge clock);
            #1;
            i++;
        end
        check("rand_drain", exp_q.size(), 0);
        repeat (3) @(negedge clock);
        check("rand_final_count", fifo_count, 0);
        check("rand_final_busy", tx_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
